// File: rtl/csa_pkg.sv
// csa_pkg: sizing helpers for the pipelined carry-save adder tree.
//   csa_rows(n, lvl)  rows remaining after lvl levels of 3:2 compression
//   csa_levels(n)     number of 3:2 levels needed to reach two rows
//   csa_ow(n, w)      result width that holds the sum of n w-bit operands
//   csa_stages(n,lps) tree register stages when a register follows every lps levels
package csa_pkg;

    // One level: every full group of three rows becomes two, leftovers pass through.
    function automatic int unsigned csa_next_rows(input int unsigned r);
        return (r > 2) ? ((r / 3) * 2 + (r % 3)) : r;
    endfunction

    function automatic int unsigned csa_rows(input int unsigned n, input int unsigned lvl);
        int unsigned r;
        r = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            r = csa_next_rows(r);
        end
        return r;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned n);
        int unsigned r;
        int unsigned l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = csa_next_rows(r);
            l++;
        end
        return l;
    endfunction

    function automatic int unsigned csa_ow(input int unsigned n, input int unsigned w);
        return w + $clog2(n);
    endfunction

    function automatic int unsigned csa_stages(input int unsigned n, input int unsigned lps);
        return (csa_levels(n) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: one row of full adders (3:2 compressor) of parametrised width.
//   x, y, z  in   W  rows to compress
//   s        out  W  bitwise sum x^y^z
//   c        out  W  majority(x,y,z) shifted left by one, truncated to W
module csa_3to2 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-1:0] maj;

    assign maj = (x & y) | (x & z) | (y & z);
    assign s   = x ^ y ^ z;
    assign c   = maj << 1;

endmodule

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined carry-save adder tree summing N operands of W bits
// into one OW = W+clog2(N) bit result, with a valid/ready full-pipeline stall.
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   in_data    in   N*W   packed operands, operand k at in_data[k*W +: W]
//   in_valid   in   1     in_data valid
//   in_ready   out  1     block accepts in_data (combinational from out_valid/out_ready)
//   out_sum    out  OW    sum of all N operands, modulo 2^OW
//   out_valid  out  1     out_sum valid
//   out_ready  in   1     downstream accepts out_sum
// Build option: define CSA_SIGNED_EN for two's complement operands and result
// (sign extension); otherwise operands are unsigned and zero-extended.
module csa_tree_pipe
    import csa_pkg::*;
#(
    parameter int unsigned N   = 25,
    parameter int unsigned W   = 4,
    parameter int unsigned LPS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*W-1:0]         in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [W+$clog2(N)-1:0] out_sum,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned OW = csa_ow(N, W);
    localparam int unsigned L  = csa_levels(N);
    localparam int unsigned S  = csa_stages(N, LPS);

    logic          advance_c;
    logic [S:0]    stage_vld;
    logic [OW-1:0] ext_rows [N];
    logic [OW-1:0] in_rows  [N];
    logic [OW-1:0] fin_a;
    logic [OW-1:0] fin_b;

    // Whole pipe moves together; it only freezes while a result is refused.
    assign advance_c = !(out_valid && !out_ready);
    assign in_ready  = advance_c;

    // Widen each operand to the result width before it enters the tree.
    for (genvar k = 0; k < N; k++) begin : g_ext
`ifdef CSA_SIGNED_EN
        assign ext_rows[k] = {{(OW-W){in_data[k*W+W-1]}}, in_data[k*W +: W]};
`else
        assign ext_rows[k] = {{(OW-W){1'b0}}, in_data[k*W +: W]};
`endif
    end

    // Input register (stage 0) and the valid bit of every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                in_rows[k] <= '0;
            end
        end else if (advance_c) begin
            stage_vld <= {stage_vld[S-1:0], in_valid};
            for (int unsigned k = 0; k < N; k++) begin
                in_rows[k] <= ext_rows[k];
            end
        end
    end

    // Compression levels; a register closes every LPS levels and the final level.
    for (genvar l = 1; l <= L; l++) begin : g_lvl
        localparam int unsigned RI = csa_rows(N, l - 1);
        localparam int unsigned RO = csa_rows(N, l);
        localparam int unsigned G  = RI / 3;

        logic [OW-1:0] d  [RI];
        logic [OW-1:0] nx [RO];
        logic [OW-1:0] q  [RO];

        for (genvar k = 0; k < RI; k++) begin : g_src
            if (l == 1) begin : g_from_in
                assign d[k] = in_rows[k];
            end else begin : g_from_prev
                assign d[k] = g_lvl[l-1].q[k];
            end
        end

        for (genvar g = 0; g < G; g++) begin : g_csa
            csa_3to2 #(
                .W (OW)
            ) u_csa (
                .x (d[3*g]),
                .y (d[3*g+1]),
                .z (d[3*g+2]),
                .s (nx[2*g]),
                .c (nx[2*g+1])
            );
        end

        // Rows that do not form a full group of three pass straight through.
        for (genvar k = 3*G; k < RI; k++) begin : g_pass
            assign nx[2*G + k - 3*G] = d[k];
        end

        if ((l % LPS == 0) || (l == L)) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < RO; i++) begin
                        q[i] <= '0;
                    end
                end else if (advance_c) begin
                    for (int unsigned i = 0; i < RO; i++) begin
                        q[i] <= nx[i];
                    end
                end
            end
        end else begin : g_comb
            for (genvar k = 0; k < RO; k++) begin : g_wire
                assign q[k] = nx[k];
            end
        end
    end

    assign fin_a = g_lvl[L].q[0];
    assign fin_b = g_lvl[L].q[1];

    // Final carry-propagate add into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (advance_c) begin
            out_valid <= stage_vld[S];
            out_sum   <= fin_a + fin_b;
        end
    end

endmodule

// File: doc/csa_tree_pipe.md
# csa_tree_pipe

Pipelined, parametrised carry-save adder tree that sums N operands of W bits each into one (W+clog2(N))-bit result. It uses levels of 3:2 compressors and pipeline registers between groups of levels. It replaces the single-cycle multi-operand adder in CNN accumulation datapaths, where N is the kernel tap count. A valid/ready handshake with full-pipeline stall lets it sit directly between the MAC products and downstream buffering.

## Interface
- N, 25, operand count; legal range 3..64.
- W, 4, operand width in bits; legal range 1..32.
- LPS, 2, compressor levels per pipeline stage; must be ≥1.
- OW (localparam), W+$clog2(N), result width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  N*W  packed operands; operand k is in_data[k*W +: W].
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- out_sum  out  OW  sum of all N operands.
- out_valid  out  1  out_sum is valid.
- out_ready  in  1  downstream accepts out_sum.

## Operation
- Tree: L = csa_levels(N) levels. Each level replaces every full group of 3 rows with 2 rows (sum, carry<<1). Leftover rows pass through unchanged. Reduction stops at 2 rows.
  - Example: N=25 gives 25→17→12→8→6→4→3→2, so L=7.
- All rows are carried at width OW. Operands are zero-extended, or sign-extended in signed mode.
- A register stage follows every LPS levels, plus after the last level if L mod LPS ≠ 0. S = ceil(L/LPS) tree stages.
- Final carry-propagate adder: the two remaining rows are added modulo 2^OW into the out_sum register.
- OW is exact for unsigned operands. No overflow is possible; cout is part of out_sum.
- Each stage has a valid bit.
- advance = !(out_valid && !out_ready). in_ready = advance.
  - When advance=1: every stage loads from its predecessor, and stage 0 valid loads in_valid.
  - When advance=0: all data and valid registers hold.
- Bubbles are not collapsed. An invalid slot travels down the pipe like data.
- Data registers load regardless of valid. Their content is don't-care while the matching valid is 0.

## Timing
- Latency = S+1 cycles, measured from the accepting edge (in_valid && in_ready) to out_valid.
  - N=25, LPS=2 gives 5 cycles. N=3, LPS=1 gives 2 cycles.
- Throughput is 1 result per cycle while out_ready=1.
- out_valid/out_sum hold stable while out_valid && !out_ready.
- in_ready is combinational from out_valid and out_ready. There is no path from in_valid to in_ready.
- Reset state: out_valid=0, out_sum=0, all stage valid bits 0, all data registers 0.
- Asynchronous reset mid-stream drops every in-flight item. No output appears for items accepted before reset.
- First accept after reset release: out_valid rises S+1 cycles later.
- Simultaneous stall release and new input: if out_ready=1 in the same cycle out_valid=1 and in_valid=1, both transfers occur at that edge.

## Configuration
- CSA_SIGNED_EN defined: operands and out_sum are two's complement.
  - Each operand is sign-extended to OW before the tree.
  - Range is N·(−2^(W−1)) .. N·(2^(W−1)−1), which always fits OW.
- CSA_SIGNED_EN undefined: operands and out_sum are unsigned, with zero-extension.
- Ports and latency are identical in both builds.

## Structure
- Package csa_pkg holds:
  - function csa_levels(n): CSA level count.
  - function csa_rows(n, lvl): row count after level lvl, used to size generate loops.
  - function csa_ow(n, w).
- Sub-module csa_3to2: bitwise full-adder row of parametrised width. Inputs x, y, z. Outputs s = x^y^z and c = maj(x,y,z) << 1, truncated to the row width.
- The top level generates levels and stage registers from csa_pkg functions. There is no hand-unrolled operand list.

## Test plan
- Settings N=25, W=4, LPS=2, unsigned, out_ready=1.
  - Input: one beat of all operands = 15.
  - Response: out_sum=375 (0x177), out_valid high exactly 5 cycles after the accept, for 1 cycle.
- Settings: same as above.
  - Input: streaming, each beat's 100-bit in_data = LFSR(seed 0xfffffffffff, taps [99]^[98], one shift per cycle), 100000 beats.
  - Response: every out_sum equals the software sum of its 25 nibbles, results in order, zero mismatches.
- Backpressure:
  - Stimulus: stream beats with values 1,2,3… and drop out_ready for cycles 10–14.
  - Response: in_ready=0 during the stall, out_sum held constant, no beat lost or duplicated, sequence 25·k preserved.
- Reset:
  - Stimulus: assert rst_n=0 for 1 cycle after accepting 3 beats.
  - Response: out_valid=0 and out_sum=0 immediately, no stale results afterwards, the next accepted beat appears after 5 cycles.
- Configuration N=3, W=8, LPS=1:
  - Input: 255,255,255.
  - Response: out_sum=765 (OW=10), latency 2 cycles.
- Signed build with CSA_SIGNED_EN, N=25, W=4:
  - Input: all operands −8. Response: out_sum=0x138 (−200).
  - Input: all operands 7. Response: 175.
